radix5_issue_sched: RTL and testbench

- Sequencer between a streaming complex-sample source and the fixed-latency, non-stallable radix-5 butterfly pipeline.
- Gathers 5 consecutive samples into a frame and issues the frame to the datapath in one cycle.
- Tracks in-flight frames with a valid shift line and captures each result frame into an output FIFO.
- Serializes results X0..X4 back out under valid/ready; a credit counter ensures a result never arrives at a full FIFO.

---
 rtl/radix5_issue_sched_pkg.sv | 38 +++
 rtl/radix5_issue_sched_frame_fifo.sv | 41 ++++
 rtl/radix5_issue_sched.sv | 137 +++++++++++++
 tb/tb_radix5_issue_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/radix5_issue_sched_pkg.sv
// radix5_pkg: shared sizes, complex/frame types and flat-bus slot packing
// helpers for the radix-5 issue scheduler.
package radix5_pkg;
  localparam int RADIX  = 5;
  localparam int IDX_W  = 3;
  localparam int CPLX_W = 32;  // component width carried by cplx_t; the top's W must match

  typedef struct packed {
    logic [CPLX_W-1:0] re;
    logic [CPLX_W-1:0] img;
  } cplx_t;

  typedef cplx_t [RADIX-1:0] frame_t;

  function automatic logic [RADIX*CPLX_W-1:0] slot_pack_re(input frame_t f);
    logic [RADIX*CPLX_W-1:0] v;
    v = '0;
    for (int k = 0; k < RADIX; k++) v[k*CPLX_W +: CPLX_W] = f[k].re;
    return v;
  endfunction

  function automatic logic [RADIX*CPLX_W-1:0] slot_pack_img(input frame_t f);
    logic [RADIX*CPLX_W-1:0] v;
    v = '0;
    for (int k = 0; k < RADIX; k++) v[k*CPLX_W +: CPLX_W] = f[k].img;
    return v;
  endfunction

  function automatic frame_t slot_unpack(input logic [RADIX*CPLX_W-1:0] re_flat,
                                         input logic [RADIX*CPLX_W-1:0] img_flat);
    frame_t f;
    for (int k = 0; k < RADIX; k++) begin
      f[k].re  = re_flat[k*CPLX_W +: CPLX_W];
      f[k].img = img_flat[k*CPLX_W +: CPLX_W];
    end
    return f;
  endfunction
endpackage

// File: rtl/radix5_issue_sched_frame_fifo.sv
// radix5_frame_fifo: DEPTH-deep store of whole result frames, head frame
// readable combinationally; pointers carry an extra wrap bit.
module radix5_frame_fifo
  import radix5_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  frame_t wr_data,
  input  logic   rd_en,
  output logic   empty,
  output logic   full,
  output frame_t head
);
  localparam int AW = $clog2(DEPTH);

  frame_t         mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/radix5_issue_sched.sv
// radix5_issue_sched: gathers 5-sample frames, issues them to a fixed-latency
// radix-5 datapath under credits, buffers and re-serialises the results.
// Optional statistics counters: define RADIX5_SCHED_STATS_EN.
module radix5_issue_sched
  import radix5_pkg::*;
#(
  parameter int W          = 32,
  parameter int DP_LAT     = 10,
  parameter int OUT_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_re,
  input  logic [W-1:0]     in_img,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [5*W-1:0]   dp_x_re,
  output logic [5*W-1:0]   dp_x_img,
  output logic             dp_issue,
  input  logic [5*W-1:0]   dp_y_re,
  input  logic [5*W-1:0]   dp_y_img,
  output logic [W-1:0]     out_re,
  output logic [W-1:0]     out_img,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef RADIX5_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_frames_issued,
  output logic [15:0]      stat_frames_out,
  output logic [15:0]      stat_credit_stalls
`endif
);
  localparam int CRED_W = $clog2(OUT_FRAMES + 1);

  logic [IDX_W-1:0]      load_idx_reg;
  logic                  frame_full_reg;
  cplx_t [RADIX-2:0]     load_bank_reg;
  frame_t                issue_bank_reg;
  logic [CRED_W-1:0]     credits_reg;
  logic [DP_LAT-1:0]     vline_reg;
  logic [IDX_W-1:0]      out_idx_reg;

  logic   in_hs, out_hs, pop, last_load, capture;
  logic   fifo_empty, fifo_full;
  frame_t fifo_head;
  cplx_t  in_sample, head_slot;

  assign in_sample = {in_re, in_img};
  assign dp_issue  = frame_full_reg && (credits_reg != '0);
  assign in_ready  = !frame_full_reg || dp_issue;
  assign in_hs     = in_valid && in_ready;
  assign last_load = (load_idx_reg == IDX_W'(RADIX-1));
  assign capture   = vline_reg[DP_LAT-1];
  assign out_valid = !fifo_empty;
  assign out_hs    = out_valid && out_ready;
  assign pop       = out_hs && (out_idx_reg == IDX_W'(RADIX-1));
  assign busy      = frame_full_reg || (load_idx_reg != '0) || (vline_reg != '0) || !fifo_empty;

  // Slot 4 goes straight into the issue bank together with slots 0..3, so the
  // load bank is free to take the next frame while dp_x_* is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_idx_reg   <= '0;
      frame_full_reg <= 1'b0;
      load_bank_reg  <= '0;
      issue_bank_reg <= '0;
    end else begin
      if (in_hs) begin
        if (last_load) begin
          load_idx_reg   <= '0;
          issue_bank_reg <= {in_sample, load_bank_reg};
        end else begin
          load_idx_reg <= load_idx_reg + IDX_W'(1);
          for (int k = 0; k < RADIX-1; k++)
            if (load_idx_reg == IDX_W'(k)) load_bank_reg[k] <= in_sample;
        end
      end
      if (in_hs && last_load) frame_full_reg <= 1'b1;
      else if (dp_issue)      frame_full_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_reg <= CRED_W'(OUT_FRAMES);
      vline_reg   <= '0;
      out_idx_reg <= '0;
    end else begin
      if (dp_issue && !pop)      credits_reg <= credits_reg - CRED_W'(1);
      else if (pop && !dp_issue) credits_reg <= credits_reg + CRED_W'(1);
      vline_reg <= (vline_reg << 1) | DP_LAT'(dp_issue);
      if (out_hs) out_idx_reg <= pop ? '0 : out_idx_reg + IDX_W'(1);
    end
  end

  radix5_frame_fifo #(.DEPTH(OUT_FRAMES)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture),
    .wr_data (slot_unpack(dp_y_re, dp_y_img)),
    .rd_en   (pop),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .head    (fifo_head)
  );

  always_comb begin
    head_slot = fifo_head[0];
    for (int k = 1; k < RADIX; k++)
      if (out_idx_reg == IDX_W'(k)) head_slot = fifo_head[k];
  end

  assign out_re   = out_valid ? head_slot.re  : '0;
  assign out_img  = out_valid ? head_slot.img : '0;
  assign dp_x_re  = slot_pack_re(issue_bank_reg);
  assign dp_x_img = slot_pack_img(issue_bank_reg);

  // Credits guarantee a free FIFO entry at every tap cycle.
  a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst_n)
                                           !(capture && fifo_full));

`ifdef RADIX5_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_issued <= '0;
      stat_frames_out    <= '0;
      stat_credit_stalls <= '0;
    end else begin
      if (dp_issue) stat_frames_issued <= stat_frames_issued + 16'd1;
      if (pop)      stat_frames_out    <= stat_frames_out + 16'd1;
      if (frame_full_reg && (credits_reg == '0))
        stat_credit_stalls <= stat_credit_stalls + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_radix5_issue_sched.sv
// Bench for radix5_issue_sched: echo-datapath model, frame-level reference
// model checked every cycle, directed scenarios plus randomized traffic.
module tb_radix5_issue_sched;
  localparam int W = 32;
  localparam int DP_LAT = 10;
  localparam int OUT_FRAMES = 4;

  typedef logic [319:0] frm_t;  // slot k = {re,img} at [k*64 +: 64]

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] in_re = '0, in_img = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, dp_issue, out_valid, busy;
  logic [5*W-1:0] dp_x_re, dp_x_img;
  logic [5*W-1:0] dp_y_re = '0, dp_y_img = '0;
  logic [W-1:0] out_re, out_img;
`ifdef RADIX5_SCHED_STATS_EN
  logic [15:0] stat_frames_issued, stat_frames_out, stat_credit_stalls;
`endif

  radix5_issue_sched #(.W(W), .DP_LAT(DP_LAT), .OUT_FRAMES(OUT_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_re(in_re), .in_img(in_img), .in_valid(in_valid), .in_ready(in_ready),
    .dp_x_re(dp_x_re), .dp_x_img(dp_x_img), .dp_issue(dp_issue),
    .dp_y_re(dp_y_re), .dp_y_img(dp_y_img),
    .out_re(out_re), .out_img(out_img), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
`ifdef RADIX5_SCHED_STATS_EN
    , .stat_frames_issued(stat_frames_issued), .stat_frames_out(stat_frames_out),
    .stat_credit_stalls(stat_credit_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [159:0] frame_re(input frm_t f);
    logic [159:0] v;
    for (int k = 0; k < 5; k++) v[k*32 +: 32] = f[k*64+32 +: 32];
    return v;
  endfunction

  function automatic logic [159:0] frame_img(input frm_t f);
    logic [159:0] v;
    for (int k = 0; k < 5; k++) v[k*32 +: 32] = f[k*64 +: 32];
    return v;
  endfunction

  // Echo datapath: y equals the issued x exactly DP_LAT edges later, noise otherwise.
  int dpq_edge[$];
  logic [159:0] dpq_re[$], dpq_img[$];
  always @(negedge clk) begin
    if (rst_n && dp_issue) begin
      dpq_edge.push_back(cyc + 1);
      dpq_re.push_back(dp_x_re);
      dpq_img.push_back(dp_x_img);
    end
    if (dpq_edge.size() > 0 && dpq_edge[0] + DP_LAT == cyc + 1) begin
      dp_y_re = dpq_re.pop_front();
      dp_y_img = dpq_img.pop_front();
      void'(dpq_edge.pop_front());
    end else begin
      for (int k = 0; k < 5; k++) begin
        dp_y_re[k*32 +: 32] = $urandom;
        dp_y_img[k*32 +: 32] = $urandom;
      end
    end
  end

  // Reference model: partial frame, pending frame, credits, in-flight and buffered frames.
  logic [63:0] ld_q[$];
  bit m_full;
  frm_t m_pend;
  int m_credits, m_oidx;
  int fl_edge[$];
  frm_t fl_frm[$];
  frm_t buf_q[$];
  logic [15:0] m_st_iss, m_st_out, m_st_stall;

  // DUT-observed event logs for the directed literal checks.
  int in_hs_edges[$], issue_edges[$], out_hs_edges[$];
  logic [159:0] issue_x_re[$];
  logic [31:0] out_vals[$];

  always @(negedge clk) begin
    bit p_ir, p_iss, p_ov, p_busy, p_pop;
    logic [63:0] p_smp;
    frm_t hf, nf;
    int e;
    e = cyc + 1;
    if (!rst_n) begin
      ld_q.delete(); fl_edge.delete(); fl_frm.delete(); buf_q.delete();
      m_full = 0; m_credits = OUT_FRAMES; m_oidx = 0;
      m_st_iss = '0; m_st_out = '0; m_st_stall = '0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_dp_issue", dp_issue, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", {out_re, out_img}, 0);
      chk("rst_dp_x", {dp_x_re, dp_x_img}, 0);
    end else begin
      p_ir = !m_full || (m_credits > 0);
      p_iss = m_full && (m_credits > 0);
      p_ov = buf_q.size() > 0;
      p_busy = m_full || ld_q.size() > 0 || fl_edge.size() > 0 || p_ov;
      chk("in_ready", in_ready, p_ir);
      chk("dp_issue", dp_issue, p_iss);
      chk("out_valid", out_valid, p_ov);
      chk("busy", busy, p_busy);
      if (m_full) begin
        chk("dp_x_re", dp_x_re, frame_re(m_pend));
        chk("dp_x_img", dp_x_img, frame_img(m_pend));
      end
      if (p_ov) begin
        hf = buf_q[0];
        p_smp = hf[m_oidx*64 +: 64];
        chk("out_data", {out_re, out_img}, p_smp);
      end
`ifdef RADIX5_SCHED_STATS_EN
      chk("stat_issued", stat_frames_issued, m_st_iss);
      chk("stat_out", stat_frames_out, m_st_out);
      chk("stat_stalls", stat_credit_stalls, m_st_stall);
`endif
      if (in_valid && in_ready) in_hs_edges.push_back(e);
      if (dp_issue) begin issue_edges.push_back(e); issue_x_re.push_back(dp_x_re); end
      if (out_valid && out_ready) begin out_hs_edges.push_back(e); out_vals.push_back(out_re); end
      // advance to the state after edge e
      p_pop = p_ov && out_ready && (m_oidx == 4);
      if (m_full && m_credits == 0) m_st_stall++;
      if (p_ov && out_ready) begin
        if (m_oidx == 4) begin
          void'(buf_q.pop_front()); m_oidx = 0; m_credits++; m_st_out++;
        end else m_oidx++;
      end
      if (fl_edge.size() > 0 && fl_edge[0] + DP_LAT == e) begin
        buf_q.push_back(fl_frm.pop_front());
        void'(fl_edge.pop_front());
      end
      if (p_iss) begin
        fl_edge.push_back(e); fl_frm.push_back(m_pend);
        m_full = 0; m_credits--; m_st_iss++;
      end
      if (in_valid && p_ir) begin
        ld_q.push_back({in_re, in_img});
        if (ld_q.size() == 5) begin
          for (int k = 0; k < 5; k++) nf[k*64 +: 64] = ld_q[k];
          m_pend = nf; m_full = 1; ld_q.delete();
        end
      end
      if (p_pop && m_oidx != 0) chk("model_pop_idx", m_oidx, 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] img);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1; in_re = re; in_img = img;
    do begin
      @(negedge clk); ok = in_ready;
      step(); n++;
    end while (!ok && n < 300);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (out_hs_edges.size() < target && n < budget) begin step(); n++; end
    if (out_hs_edges.size() < target) chk(name, out_hs_edges.size(), target);
  endtask

  initial begin
    int bi, bs, bo;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Output stalled: four credits allow four issues, frame 5 waits.
    bi = in_hs_edges.size(); bs = issue_edges.size(); bo = out_hs_edges.size();
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) send(1000 + i, 2000 + i);
    in_valid = 1'b0;
    repeat (20) step();
    chk("s2_issues", issue_edges.size() - bs, 4);
    chk("s2_in_ready", in_ready, 0);
    chk("s2_busy", busy, 1);
    out_ready = 1'b1;
    wait_out("s2_drain_timeout", bo + 25, 400);
    if (out_hs_edges.size() >= bo + 25) begin
      for (int i = 0; i < 25; i++) chk("s2_order", out_vals[bo + i], 1000 + i);
      chk("s2_issue_after_pop", issue_edges[bs + 4], out_hs_edges[bo + 4] + 1);
    end
    repeat (5) step();
`ifdef RADIX5_SCHED_STATS_EN
    chk("st_issued_lit", stat_frames_issued, 5);
    chk("st_out_lit", stat_frames_out, 5);
    chk("st_stall_nonzero", stat_credit_stalls != 0, 1);
`endif

    // Stream 1..10 with free output.
    bi = in_hs_edges.size(); bs = issue_edges.size(); bo = out_hs_edges.size();
    for (int i = 1; i <= 10; i++) send(i, 0);
    in_valid = 1'b0;
    wait_out("s1_timeout", bo + 10, 200);
    chk("s1_busy_after_pop", busy, 0);
    chk("s1_issue1_lat", issue_edges[bs], in_hs_edges[bi + 4] + 1);
    chk("s1_issue2_lat", issue_edges[bs + 1], in_hs_edges[bi + 9] + 1);
    chk("s1_first_out_lat", out_hs_edges[bo], in_hs_edges[bi + 4] + DP_LAT + 2);
    for (int i = 0; i < 10; i++) chk("s1_out_val", out_vals[bo + i], i + 1);
    step();

    // Input gap inside one frame.
    bs = issue_edges.size(); bo = out_hs_edges.size();
    for (int i = 0; i < 3; i++) send(101 + i, 7);
    in_valid = 1'b0;
    repeat (7) step();
    for (int i = 3; i < 5; i++) send(101 + i, 7);
    in_valid = 1'b0;
    wait_out("gap_timeout", bo + 5, 200);
    chk("gap_issues", issue_edges.size() - bs, 1);
    chk("gap_slots", issue_x_re[bs], {32'd105, 32'd104, 32'd103, 32'd102, 32'd101});

    // Reset with two frames in flight and three samples loaded.
    bs = issue_edges.size();
    for (int i = 0; i < 13; i++) send($urandom, $urandom);
    in_valid = 1'b0;
    chk("mr_inflight", issue_edges.size() - bs, 2);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    step();
    rst_n = 1'b1;
    bo = out_hs_edges.size(); bs = issue_edges.size();
    repeat (30) step();
    chk("mr_no_stale_out", out_hs_edges.size(), bo);
    chk("mr_no_issue", issue_edges.size(), bs);

    // Randomized traffic with alternating output back-pressure.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_re = $urandom; in_img = $urandom;
      out_ready = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (150) step();
    chk("final_drained", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
